// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, round-constant table and key-schedule FSM encoding.
// Holds the state/key/word/byte typedefs, AES_NB, the Rcon table and ks_state_t.
// Used by round_key_add, round_key_add_if and aes_sbox.
package aes_pkg;

  localparam int AES_NB = 4;  // 32-bit words per state / round key

  typedef logic [127:0] state_t;
  typedef logic [127:0] key_t;
  typedef logic [31:0]  word_t;
  typedef logic [7:0]   byte_t;

  // Key-schedule FSM: no key loaded, key ready, generating next key, last round used.
  typedef enum logic [1:0] {
    NOKEY = 2'd0,
    RDY   = 2'd1,
    GEN   = 2'd2,
    DONE  = 2'd3
  } ks_state_t;

  // Round constant indexed by the round whose key is being produced (1..10).
  localparam logic [10:1][7:0] RCON = {
    8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01
  };

  // Out-of-range rounds return 0 so the lookup is always defined.
  function automatic byte_t rcon_for(logic [3:0] rnd);
    byte_t r;
    r = 8'h00;
    if (rnd >= 4'd1 && rnd <= 4'd10) r = RCON[rnd];
    return r;
  endfunction

  // RotWord: cyclic left rotate by one byte.
  function automatic word_t rot_word(word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/round_key_add_if.sv
// round_key_add_if: state-in / state-out handshake bundle of round_key_add.
// slave  : the round_key_add side (consumes state_in, produces state_out).
// master : the surrounding datapath (mix_col upstream and the next stage downstream).
interface round_key_add_if;
  import aes_pkg::*;

  logic   in_valid;
  logic   in_ready;
  state_t state_in;
  logic   out_valid;
  logic   out_ready;
  state_t state_out;
  logic   out_last;

  modport slave (
    input  in_valid, state_in, out_ready,
    output in_ready, out_valid, state_out, out_last
  );

  modport master (
    output in_valid, state_in, out_ready,
    input  in_ready, out_valid, state_out, out_last
  );

endinterface

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES S-box, one byte in, one byte out.
// Ports: a (input byte), s (substituted byte).
// Computed as GF(2^8) inverse (x^254) followed by the affine transform, so no table.
module aes_sbox
  import aes_pkg::*;
(
  input  byte_t a,
  output byte_t s
);

  // Multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1.
  function automatic byte_t xtime(byte_t x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t gf_mul(byte_t x, byte_t y);
    byte_t p;
    byte_t t;
    p = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // x^254 == x^-1 for x != 0, and maps 0 to 0 as the S-box requires.
  // 254 = 8'b1111_1110: square every step, multiply on bits 7..1.
  function automatic byte_t gf_inv(byte_t x);
    byte_t r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (i != 0) r = gf_mul(r, x);
    end
    return r;
  endfunction

  byte_t inv;

  always_comb begin
    inv = gf_inv(a);
    // Affine: b_i = x_i ^ x_(i+4) ^ x_(i+5) ^ x_(i+6) ^ x_(i+7) ^ c_i, c = 0x63.
    s = inv
      ^ {inv[6:0], inv[7]}
      ^ {inv[5:0], inv[7:6]}
      ^ {inv[4:0], inv[7:5]}
      ^ {inv[3:0], inv[7:4]}
      ^ 8'h63;
  end

endmodule

// File: rtl/round_key_add.sv
// round_key_add: AES-128 AddRoundKey with an iterative on-the-fly key schedule.
// Ports: clk, rst (async, active-high), key_load/key_in (round-0 key capture),
//   bus (round_key_add_if.slave: in_valid/in_ready/state_in, out_valid/out_ready/
//   state_out/out_last), round_idx (round of the held key), key_busy (FSM in GEN).
// Latency 1 cycle state_in -> state_out; one state per 5 cycles while the next
//   round key is built one word per cycle; output register stalls on !out_ready.
// Optional build macro RKA_ZEROIZE_EN: clear the key and round_idx on entry to DONE.
module round_key_add
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   key_load,
  input  key_t   key_in,
  round_key_add_if.slave bus,
  output logic [3:0] round_idx,
  output logic   key_busy
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);
  localparam logic [1:0] LAST_WORD  = 2'(AES_NB - 1);

  ks_state_t  state_q, state_d;
  key_t       key_q, key_gen;
  logic [3:0] round_q;
  logic [1:0] wcnt_q;

  state_t     out_q;
  logic       out_vld_q;
  logic       out_last_q;

  logic       xfer;
  logic       at_last_round;
  logic       gen_last;
  word_t      w3_rot;
  word_t      sub_w;
  word_t      new_word;

  // ---------------------------------------------------------------- handshake
  // key_load blocks acceptance so the state is never XORed with a key that is
  // being replaced in the same cycle.
  assign bus.in_ready = (state_q == RDY) && !key_load && (!out_vld_q || bus.out_ready);
  assign xfer         = bus.in_valid && bus.in_ready;

  assign at_last_round = (round_q == LAST_ROUND);
  assign gen_last      = (state_q == GEN) && (wcnt_q == LAST_WORD);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= NOKEY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (key_load) begin
      state_d = RDY;
    end else begin
      case (state_q)
        RDY:     if (xfer) state_d = at_last_round ? DONE : GEN;
        GEN:     if (gen_last) state_d = RDY;
        default: state_d = state_q;
      endcase
    end
  end

  // ---------------------------------------------------------------- key schedule
  // SubWord(RotWord(w3)) of the key currently held; only consumed on word 0.
  assign w3_rot = rot_word(key_q[31:0]);

  for (genvar b = 0; b < AES_NB; b++) begin : g_sbox
    aes_sbox u_sbox (
      .a (w3_rot[8*b +: 8]),
      .s (sub_w[8*b +: 8])
    );
  end

  // Words are updated in place, so for j>0 the already-rewritten word j-1 is
  // exactly w(j-1)' of the new round key.
  always_comb begin
    key_gen  = key_q;
    new_word = '0;
    case (wcnt_q)
      2'd0: begin
        new_word        = key_q[127:96] ^ sub_w ^ {rcon_for(round_q + 4'd1), 24'h0};
        key_gen[127:96] = new_word;
      end
      2'd1: begin
        new_word        = key_q[95:64] ^ key_q[127:96];
        key_gen[95:64]  = new_word;
      end
      2'd2: begin
        new_word        = key_q[63:32] ^ key_q[95:64];
        key_gen[63:32]  = new_word;
      end
      default: begin
        new_word        = key_q[31:0] ^ key_q[63:32];
        key_gen[31:0]   = new_word;
      end
    endcase
  end

  // key_load wins over everything, including a half-built key in GEN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q   <= '0;
      round_q <= '0;
      wcnt_q  <= '0;
    end else if (key_load) begin
      key_q   <= key_in;
      round_q <= '0;
      wcnt_q  <= '0;
    end else begin
      case (state_q)
        GEN: begin
          key_q  <= key_gen;
          wcnt_q <= wcnt_q + 2'd1;  // wraps to 0 after the last word
          if (gen_last) round_q <= round_q + 4'd1;
        end
`ifdef RKA_ZEROIZE_EN
        RDY: begin
          // The output register still samples the old key on this edge.
          if (xfer && at_last_round) begin
            key_q   <= '0;
            round_q <= '0;
          end
        end
`endif
        default: begin
          wcnt_q <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- output register
  // Reloads on accept (also when draining in the same cycle, so no bubble);
  // otherwise clears valid once the downstream takes the data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
    end else if (xfer) begin
      out_q      <= bus.state_in ^ key_q;
      out_vld_q  <= 1'b1;
      out_last_q <= at_last_round;
    end else if (bus.out_ready) begin
      out_vld_q  <= 1'b0;
    end
  end

  assign bus.out_valid = out_vld_q;
  assign bus.state_out = out_q;
  assign bus.out_last  = out_last_q;
  assign round_idx     = round_q;
  assign key_busy      = (state_q == GEN);

endmodule

// File: tb/tb_round_key_add.sv
module tb_round_key_add;
  import aes_pkg::*;

  localparam int NR = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_load;
  key_t       key_in;
  logic [3:0] round_idx;
  logic       key_busy;

  round_key_add_if bus ();

  round_key_add #(.NUM_ROUNDS(NR)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_load  (key_load),
    .key_in    (key_in),
    .bus       (bus.slave),
    .round_idx (round_idx),
    .key_busy  (key_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ------------------------------------------------------------ reference model
  byte_t sbox_tab [256];
  key_t  rk [0:NR];

  function automatic byte_t mul(byte_t a, byte_t b);
    byte_t p;
    byte_t x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = (x[7]) ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  // Inverse by exhaustive search, then the textbook bitwise affine map.
  task automatic build_sbox();
    byte_t inv;
    byte_t s;
    byte_t c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_tab[x] = s;
    end
  endtask

  // FIPS-197 key expansion over a flat word array; Rcon by repeated doubling.
  task automatic expand(input key_t k);
    word_t w [4*(NR+1)];
    word_t t;
    byte_t rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 4*(NR+1); i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]], sbox_tab[t[31:24]]}
            ^ {rc, 24'h0};
        rc = mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ------------------------------------------------------------ drive helpers
  task automatic load_key(input key_t k);
    key_load = 1'b1;
    key_in   = k;
    @(negedge clk);
    key_load = 1'b0;
  endtask

  // Offer one state, wait (bounded) for acceptance; returns at the negedge
  // after the accepting edge, where state_out holds the result.
  task automatic push(input string name, input state_t s);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.state_in = s;
    for (int i = 0; i < 50 && !ok; i++) begin
      #1;
      if (bus.in_ready) ok = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check({name, "_accept"}, ok, 1);
  endtask

  // Counts consecutive key_busy cycles starting at the current negedge.
  task automatic busy_len(output int n);
    n = 0;
    while (key_busy && n < 20) begin
      n++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    state_t     st;
    state_t     rkey;
    logic       last;
    logic [3:0] rnd;
  } vec_t;

  typedef struct packed {
    state_t d;
    logic   l;
  } exp_t;

  localparam key_t FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam key_t KEY2     = 128'h000102030405060708090a0b0c0d0e0f;

  vec_t tab [11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   accepted;
    int   received;
    bit   took;
    key_t rkey;
    exp_t exq [$];
    exp_t e;

    tab[0]  = '{128'h0, 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, 4'd0};
    tab[1]  = '{128'h0, 128'ha0fafe1788542cb123a339392a6c7605, 1'b0, 4'd1};
    tab[2]  = '{128'h0, 128'hf2c295f27a96b9435935807a7359f67f, 1'b0, 4'd2};
    tab[3]  = '{128'h00112233445566778899aabbccddeeff,
                128'h3d80477d4716fe3e1e237e446d7a883b, 1'b0, 4'd3};
    tab[4]  = '{128'h0, 128'hef44a541a8525b7fb671253bdb0bad00, 1'b0, 4'd4};
    tab[5]  = '{128'h0, 128'hd4d1c6f87c839d87caf2b8bc11f915bc, 1'b0, 4'd5};
    tab[6]  = '{128'h0, 128'h6d88a37a110b3efddbf98641ca0093fd, 1'b0, 4'd6};
    tab[7]  = '{128'hffffffffffffffffffffffffffffffff,
                128'h4e54f70e5f5fc9f384a64fb24ea6dc4f, 1'b0, 4'd7};
    tab[8]  = '{128'h0, 128'head27321b58dbad2312bf5607f8d292f, 1'b0, 4'd8};
    tab[9]  = '{128'h0, 128'hac7766f319fadc2128d12941575c006e, 1'b0, 4'd9};
    tab[10] = '{128'h0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1, 4'd10};

    build_sbox();

    rst          = 1'b1;
    key_load     = 1'b0;
    key_in       = '0;
    bus.in_valid = 1'b0;
    bus.state_in = '0;
    bus.out_ready = 1'b1;

    // ---------------- reset state
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_state_out", bus.state_out, 0);
    check("rst_out_last",  bus.out_last, 0);
    check("rst_in_ready",  bus.in_ready, 0);
    check("rst_round_idx", round_idx, 0);
    check("rst_key_busy",  key_busy, 0);
    @(negedge clk);
    rst = 1'b0;

    // No key yet: offered state must not be accepted.
    bus.in_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("nokey_in_ready", bus.in_ready, 0);
    check("nokey_out_valid", bus.out_valid, 0);
    bus.in_valid = 1'b0;

    // ---------------- FIPS-197 table: all 11 rounds
    load_key(FIPS_KEY);
    for (int i = 0; i <= NR; i++) begin
      push($sformatf("tab%0d", i), tab[i].st);
      check($sformatf("tab%0d_state_out", i), bus.state_out, tab[i].st ^ tab[i].rkey);
      check($sformatf("tab%0d_out_last", i), bus.out_last, tab[i].last);
      check($sformatf("tab%0d_out_valid", i), bus.out_valid, 1);
      if (i < NR) begin
        check($sformatf("tab%0d_round_idx", i), round_idx, tab[i].rnd);
        busy_len(n);
        check($sformatf("tab%0d_busy_cycles", i), n, 4);
        check($sformatf("tab%0d_next_round", i), round_idx, tab[i].rnd + 4'd1);
      end
    end
    // DONE: offers are ignored.
    bus.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("done_in_ready", bus.in_ready, 0);
    check("done_key_busy", key_busy, 0);
    check("done_out_valid_drained", bus.out_valid, 0);
`ifdef RKA_ZEROIZE_EN
    check("done_key_zero", dut.key_q, 0);
    check("done_round_idx", round_idx, 0);
`else
    check("done_key_kept", dut.key_q, tab[10].rkey);
    check("done_round_idx", round_idx, NR);
`endif
    bus.in_valid = 1'b0;

    // ---------------- backpressure: hold, then drain + accept same cycle
    expand(FIPS_KEY);
    @(negedge clk);
    load_key(FIPS_KEY);
    bus.out_ready = 1'b0;
    push("hold0", 128'h0123456789abcdef0123456789abcdef);
    busy_len(n);
    bus.in_valid = 1'b1;
    bus.state_in = 128'hdeadbeefcafef00d1122334455667788;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("hold_in_ready%0d", i), bus.in_ready, 0);
      @(negedge clk);
    end
    check("hold_state_out", bus.state_out, 128'h0123456789abcdef0123456789abcdef ^ rk[0]);
    check("hold_out_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    #1;
    check("release_in_ready", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("release_state_out", bus.state_out, 128'hdeadbeefcafef00d1122334455667788 ^ rk[1]);
    check("release_out_valid", bus.out_valid, 1);

    // ---------------- key_load during GEN cycle 2
    busy_len(n);
    load_key(FIPS_KEY);
    push("kl_a", 128'h0);
    @(negedge clk);                       // second GEN cycle
    check("kl_busy_before", key_busy, 1);
    load_key(KEY2);
    check("kl_round_idx", round_idx, 0);
    check("kl_key_busy", key_busy, 0);
    #1;
    check("kl_in_ready", bus.in_ready, 1);
    push("kl_b", 128'h55555555aaaaaaaa33333333cccccccc);
    check("kl_state_out0", bus.state_out, 128'h55555555aaaaaaaa33333333cccccccc ^ KEY2);
    expand(KEY2);
    push("kl_c", 128'h0);
    check("kl_state_out1", bus.state_out, rk[1]);

    // ---------------- randomized: random keys, random valid/ready
    for (int k = 0; k < 4; k++) begin
      busy_len(n);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      rkey = {$urandom(), $urandom(), $urandom(), $urandom()};
      expand(rkey);
      load_key(rkey);
      accepted = 0;
      received = 0;
      took     = 1'b0;
      exq.delete();
      for (int cyc = 0; cyc < 600 && received < NR + 1; cyc++) begin
        if (!bus.in_valid || took) begin
          bus.in_valid = ($urandom_range(0, 3) != 0);
          bus.state_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        bus.out_ready = ($urandom_range(0, 3) != 0);
        #1;
        took = bus.in_valid && bus.in_ready;
        if (took) begin
          if (accepted <= NR) exq.push_back('{bus.state_in ^ rk[accepted], accepted == NR});
          accepted++;
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exq.size() == 0) begin
            check($sformatf("rnd%0d_unexpected_out", k), 1, 0);
          end else begin
            e = exq.pop_front();
            check($sformatf("rnd%0d_state_out%0d", k, received), bus.state_out, e.d);
            check($sformatf("rnd%0d_out_last%0d", k, received), bus.out_last, e.l);
          end
          received++;
        end
        @(negedge clk);
      end
      bus.in_valid = 1'b0;
      check($sformatf("rnd%0d_received", k), received, NR + 1);
      check($sformatf("rnd%0d_accepted", k), accepted, NR + 1);
    end

    // ---------------- async reset mid-GEN
    bus.out_ready = 1'b1;
    @(negedge clk);
    load_key(FIPS_KEY);
    push("rg", 128'h0f0e0d0c0b0a09080706050403020100);
    @(negedge clk);
    check("rg_busy", key_busy, 1);
    rst = 1'b1;
    #1;
    check("rg_out_valid", bus.out_valid, 0);
    check("rg_state_out", bus.state_out, 0);
    check("rg_out_last",  bus.out_last, 0);
    check("rg_in_ready",  bus.in_ready, 0);
    check("rg_round_idx", round_idx, 0);
    check("rg_key_busy",  key_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/round_key_add.md
Name: round_key_add

Overview:
- AES-128 AddRoundKey stage with an on-the-fly iterative key schedule.
- Sits directly downstream of mix_col in the round datapath. It consumes the 128-bit mixed state and XORs it with the current round key.
- After each state is accepted, the next round key is generated one word per cycle. Round keys are never stored in a table.
- Accepts round 0 (initial whitening) through round NUM_ROUNDS (final round, which bypasses MixColumns upstream).

Parameters:
- NUM_ROUNDS, 10: last round index. Legal range 1..10; values below 10 exist only for reduced-round testing.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- key_load  input  1  one-cycle pulse; captures key_in as the round-0 key.
- key_in  input  128  cipher key; w0 = key_in[127:96], byte 0 = [127:120].
- in_valid  input  1  state_in valid.
- in_ready  output  1  block can accept state_in this cycle.
- state_in  input  128  state from mix_col/shift path; same byte order as key_in.
- out_valid  output  1  state_out valid.
- out_ready  input  1  downstream accepts state_out.
- state_out  output  128  state_in XOR round key.
- out_last  output  1  state_out used round NUM_ROUNDS key; qualified by out_valid.
- round_idx  output  4  index of the key currently held (0..NUM_ROUNDS).
- key_busy  output  1  high while the key FSM is in GEN.

Behaviour:
- Reset: FSM=NOKEY, key register=0, round_idx=0, word counter=0, out_valid=0, state_out=0, out_last=0, in_ready=0, key_busy=0.
- FSM states: NOKEY, RDY, GEN, DONE.
- key_load, any state, including mid-GEN: next cycle key register=key_in, round_idx=0, word counter=0, FSM=RDY. Any GEN in progress is aborted. The output register is untouched.
- in_ready = (FSM==RDY) && !key_load && (!out_valid || out_ready).
- Handshake: a transfer occurs on in_valid && in_ready.
  - Next cycle: state_out = state_in ^ key, out_valid=1, out_last = (round_idx==NUM_ROUNDS).
  - Latency 1 cycle.
- Output register: holds its value while out_valid && !out_ready. out_valid clears on out_ready when no new transfer occurs in the same cycle. Simultaneous drain and new accept reloads the register with no bubble.
- After a transfer with round_idx < NUM_ROUNDS: FSM=GEN for exactly 4 cycles, computing w[4r+j], j=0..3, one word per cycle.
  - j=0: w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}.
  - j>0: wj' = wj ^ w(j-1)'.
  - Then round_idx += 1 and FSM=RDY.
- Rcon by target round 1..10: 01,02,04,08,10,20,40,80,1B,36.
- After a transfer with round_idx == NUM_ROUNDS: FSM=DONE and in_ready stays 0 until key_load. DONE keeps the key (see optional feature).
- Throughput: one state per 5 cycles, except round 0 is available 1 cycle after key_load.
- in_valid while in NOKEY/GEN/DONE: ignored and not accepted; the upstream must hold.
- Async reset mid-GEN: immediate return to reset values; the partial key is discarded.

Optional Feature:
- Macro: RKA_ZEROIZE_EN.
- Defined: on entry to DONE, the key register is cleared to 0 in the same cycle, and round_idx reads 0 while in DONE.
- Undefined: the key register keeps the round-NUM_ROUNDS key and round_idx holds NUM_ROUNDS in DONE.
- Datapath outputs are identical in both builds.

Decomposition:
- Shared package aes_pkg holds:
  - state/key/word typedefs (128/32/8 bit);
  - the Rcon constant array;
  - the FSM state encoding;
  - the AES_NB=4 constant.
- One natural sub-module: aes_sbox (8-bit combinational S-box lookup), instantiated 4x for SubWord. It is reusable by the upcoming sub_bytes stage.

Test Plan:
- Key 2b7e151628aed2a6abf7158809cf4f3c loaded, then state_in=0 → state_out=2b7e151628aed2a6abf7158809cf4f3c one cycle after accept, out_last=0, round_idx=0.
- Accept round 0, wait for RDY, state_in=0 → key_busy high exactly 4 cycles; round_idx=1; state_out=a0fafe1788542cb123a339392a6c7605.
- Feed 11 zero states back-to-back with out_ready=1 → 11th state_out=d014f9a8c9ee2589e13f0cc8b6630ca6 with out_last=1; FSM=DONE and in_ready=0.
- Hold out_ready=0 with a pending output, in_valid=1 → in_ready=0 and state_out stable; release out_ready → drain and accept in the same cycle.
- key_load during GEN cycle 2 with a new key → round_idx=0, next output = state_in ^ new key, no stale words.
- Assert rst mid-GEN → all outputs 0 immediately. With RKA_ZEROIZE_EN defined, after the round-10 accept the internal key reads 0.
